// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 encodings, frame constants and command bytes
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [3:0] PS2_BITCNT_MAX = 4'(PS2_FRAME_BITS);

  localparam logic [7:0] PS2_CMD_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_EN  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RST = 8'hFF;

  // Host-sent portion after the start bit: {stop, odd parity, data}, shifted out LSB first.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// rtl/ps2_edge_sync.sv - pin synchronizers and registered ps2_clk falling-edge detector
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_fall_q, clk_fall_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_fall_d  = clk_sync_q[2] & ~clk_sync_q[1];
  end

  // Idle bus is high, so reset the chains high to avoid a false fall after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      clk_fall_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_fall_q  <= clk_fall_d;
    end
  end

  assign clk_sync  = clk_sync_q[1];
  assign data_sync = data_sync_q[1];
  assign clk_fall  = clk_fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter, open-drain pull-low drive
// Optional device-clock watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HOLD_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int HOLD_W = $clog2(CLK_HOLD_CYCLES + 1);

  ps2_state_e        state_q, state_d;
  logic [9:0]        shift_q, shift_d;
  logic [3:0]        bitcnt_q, bitcnt_d, bitcnt_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              data_oe_q, data_oe_d;
  logic              ack_err_q, ack_err_d;
  logic              tx_err_q, tx_err_d;
  logic              tx_done_q, tx_done_d;

  logic clk_sync, data_sync, clk_fall;

  ps2_edge_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign bitcnt_inc = (bitcnt_q == PS2_BITCNT_MAX) ? bitcnt_q : bitcnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    hold_d    = hold_q;
    data_oe_d = data_oe_q;
    ack_err_d = ack_err_q;
    tx_err_d  = tx_err_q;
    tx_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hold_d    = '0;
        bitcnt_d  = '0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d = ps2_tx_frame(tx_data);
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (hold_q == HOLD_W'(CLK_HOLD_CYCLES - 1)) begin
          state_d   = ST_REQ;
          data_oe_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      // Start bit is already on the wire; each fall presents the next frame bit.
      ST_REQ, ST_DATA: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bitcnt_d  = bitcnt_inc;
          state_d   = (bitcnt_q == 4'd9) ? ST_ACK : ST_DATA;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          ack_err_d = data_sync;
          bitcnt_d  = bitcnt_inc;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_sync && data_sync) begin
          tx_done_d = 1'b1;
          tx_err_d  = ack_err_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wdog_d = '0;
    if (state_q inside {ST_REQ, ST_DATA, ST_ACK, ST_WAIT_IDLE} && !clk_fall) begin
      if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
        tx_done_d = 1'b1;
        tx_err_d  = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      hold_q    <= '0;
      data_oe_q <= 1'b0;
      ack_err_q <= 1'b0;
      tx_err_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      hold_q    <= hold_d;
      data_oe_q <= data_oe_d;
      ack_err_q <= ack_err_d;
      tx_err_q  <= tx_err_d;
      tx_done_q <= tx_done_d;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = (state_q == ST_INHIBIT);
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain device model
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       ps2_clk_in, ps2_data_in;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.CLK_HOLD_CYCLES(20), .TIMEOUT_CYCLES(500)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always @(posedge clk) if (tx_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at the first negedge where ps2_clk is released (REQ entered).
  task automatic start_tx(input logic [7:0] b, output int hold, output logic oe_at_rel);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    hold = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!ps2_clk_oe) break;
      hold++;
      @(negedge clk);
    end
    oe_at_rel = ps2_data_oe;
  endtask

  task automatic wait_done(output logic seen, output logic err, output logic rdy);
    seen = 1'b0; err = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1; err = tx_err; rdy = tx_ready;
        break;
      end
    end
  endtask

  // Device: 40 sys clk per bit, samples the bus on each rising edge.
  task automatic dev_xfer(input logic ack, input int nfalls, output logic [9:0] bits, output logic rts);
    bits = '0;
    rts  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ps2_clk_in && !ps2_data_in) begin
        rts = 1'b1;
        break;
      end
    end
    if (!rts) return;
    repeat (10) @(negedge clk);
    for (int n = 1; n <= nfalls; n++) begin
      if (n == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      if (n == nfalls && nfalls < 11) return;
      dev_clk = 1'b1;
      if (n <= 10) bits[n-1] = ps2_data_in;
      repeat (20) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input logic ack,
                           input logic [9:0] exp_bits, input logic exp_err, input logic poke);
    int         hold;
    int         d0;
    logic       oer, seen, err, rdy, rts;
    logic [9:0] bits;
    d0 = done_cnt;
    fork
      begin
        start_tx(b, hold, oer);
        wait_done(seen, err, rdy);
      end
      dev_xfer(ack, 11, bits, rts);
      if (poke) begin
        repeat (30) @(negedge clk);
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        repeat (100) @(negedge clk);
        check({name, "_busy"}, {tx_ready, busy}, 2'b01);
        repeat (100) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    @(negedge clk);
    check({name, "_hold"}, hold, 20);
    check({name, "_start"}, oer, 1'b1);
    check({name, "_rts"}, rts, 1'b1);
    check({name, "_bits"}, bits, exp_bits);
    check({name, "_done"}, seen, 1'b1);
    check({name, "_err"}, err, exp_err);
    check({name, "_rdy"}, rdy, 1'b1);
    check({name, "_pulse"}, tx_done, 1'b0);
    check({name, "_ndone"}, done_cnt - d0, 1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int         hold, d0;
    logic       oer, rts;
    logic [9:0] bits;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", {tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 6'b100000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame("led",  8'hED, 1'b1, 10'h3ED, 1'b0, 1'b0);
    run_frame("en",   8'hF4, 1'b1, 10'h2F4, 1'b0, 1'b0);
    run_frame("noack", 8'h00, 1'b0, 10'h300, 1'b1, 1'b0);
    run_frame("ign",  8'hFF, 1'b1, 10'h3FF, 1'b0, 1'b1);

    d0 = done_cnt;
    start_tx(8'hED, hold, oer);
    dev_xfer(1'b1, 5, bits, rts);
    check("abort_lownib", bits[3:0], 4'hD);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_nodone", done_cnt - d0, 0);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int   cnt;
      logic seen;
      start_tx(8'hF4, hold, oer);
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        cnt++;
        if (tx_done) begin
          seen = 1'b1;
          break;
        end
      end
      check("to_done", seen, 1'b1);
      check("to_cycles", cnt, 500);
      check("to_outs", {tx_err, ps2_clk_oe, ps2_data_oe, tx_ready}, 4'b1001);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
